// File: rtl/twiddle_stream_gen.sv
// twiddle_stream_gen
//
// Streaming twiddle-factor generator for the parallel FFT datapath.
// A start request programs a base index, an index step and a beat count. The block
// then emits that many beats. Each beat carries LANES complex twiddles
// W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), where k = k_base + i*k_step mod N.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst_n      asynchronous active-low reset
//   start      request pulse, sampled only while busy = 0
//   k_base     first twiddle index, sampled with start
//   k_step     index increment per twiddle, sampled with start
//   beats      number of output beats (0 = request ignored), sampled with start
//   inverse    (only with TWIDDLE_STREAM_INVERSE_EN) emit conjugate twiddles
//   busy       request in progress
//   out_valid  out_data / out_last valid
//   out_ready  consumer accepts the beat when out_valid & out_ready
//   out_data   packed twiddles; lane 0 in MSBs, each lane {re, im}
//   out_last   final beat of a request
//
// Optional feature macro: TWIDDLE_STREAM_INVERSE_EN adds the inverse input.
//
// Pipeline: index compute -> quarter-wave table read -> quadrant fold register.
// All three stages share one enable (!out_valid | out_ready).

module twiddle_stream_gen #(
   parameter int unsigned NBITS = 11,
   parameter int unsigned LOG2N = 7,
   parameter int unsigned LANES = 4,
   parameter int unsigned CNTW  = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [LOG2N-1:0]            k_base,
   input  logic [LOG2N-1:0]            k_step,
   input  logic [CNTW-1:0]             beats,
`ifdef TWIDDLE_STREAM_INVERSE_EN
   input  logic                        inverse,
`endif
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2*NBITS*LANES-1:0]    out_data,
   output logic                        out_last
);

   localparam int unsigned N  = 1 << LOG2N;
   localparam int unsigned Q  = N / 4;
   localparam int unsigned IW = LOG2N - 1;  // index width covering 0..Q
   localparam int unsigned W  = 2 * NBITS * LANES;
   localparam real         Pi = 3.14159265358979323846;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   // Quarter-wave cosine table, C[m] = round(cos(2*pi*m/N) * 2^(NBITS-2)).
   // All entries are non-negative, so +0.5 then truncate rounds ties away from zero.
   logic [NBITS-1:0] ctab [Q+1];

   for (genvar m = 0; m <= Q; m++) begin : g_tab
      localparam int CV = $rtoi($cos(2.0 * Pi * real'(m) / real'(N)) *
                                real'(1 << (NBITS - 2)) + 0.5);
      assign ctab[m] = NBITS'(CV);
   end

   // Request registers
   state_e             state_q, state_d;
   logic [LOG2N-1:0]   kb_q;
   logic [LOG2N-1:0]   step_q;
   logic [CNTW-1:0]    cnt_q;
   logic               inv_eff;

   logic               en;
   logic               latch;
   logic               issue;

   // Pipeline registers
   logic               s1_valid_q, s1_last_q;
   logic [LOG2N-1:0]   s1_k_q   [LANES];
   logic [LOG2N-1:0]   s1_k_d   [LANES];
   logic               s2_valid_q, s2_last_q;
   logic [1:0]         s2_quad_q [LANES];
   logic [1:0]         s2_quad_d [LANES];
   logic [NBITS-1:0]   s2_cr_q  [LANES];
   logic [NBITS-1:0]   s2_cr_d  [LANES];
   logic [NBITS-1:0]   s2_cqr_q [LANES];
   logic [NBITS-1:0]   s2_cqr_d [LANES];
   logic [W-1:0]       fold_d;

   logic [IW-1:0]      idx_r, idx_qr;
   logic [NBITS-1:0]   re_v, im_v;

   assign en = !out_valid || out_ready;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start && (beats != '0)) state_d = StRun;
         StRun:   if (issue && (cnt_q == CNTW'(1))) state_d = StDrain;
         StDrain: if (out_valid && out_ready && out_last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy  = (state_q != StIdle);
      latch = (state_q == StIdle) && start && (beats != '0);
      issue = (state_q == StRun) && en;
   end

   // kb_q always holds the index of lane 0 of the next beat to issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kb_q   <= '0;
         step_q <= '0;
         cnt_q  <= '0;
      end else if (latch) begin
         kb_q   <= k_base;
         step_q <= k_step;
         cnt_q  <= beats;
      end else if (issue) begin
         kb_q   <= kb_q + LOG2N'(LANES) * step_q;
         cnt_q  <= cnt_q - CNTW'(1);
      end
   end

`ifdef TWIDDLE_STREAM_INVERSE_EN
   logic inv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inv_q <= 1'b0;
      end else if (latch) begin
         inv_q <= inverse;
      end
   end

   // A new request can only latch once the pipeline is empty, so every
   // in-flight beat belongs to the currently latched request.
   assign inv_eff = inv_q;
`else
   assign inv_eff = 1'b0;
`endif

   // Stage 1: per-lane index, wrapping mod N
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         s1_k_d[l] = kb_q + LOG2N'(l) * step_q;
      end
   end

   // Stage 2: table read of C[r] and C[Q-r]
   always_comb begin
      idx_r  = '0;
      idx_qr = '0;
      for (int l = 0; l < LANES; l++) begin
         idx_r        = {1'b0, s1_k_q[l][LOG2N-3:0]};
         idx_qr       = IW'(Q) - idx_r;
         s2_quad_d[l] = s1_k_q[l][LOG2N-1:LOG2N-2];
         s2_cr_d[l]   = ctab[idx_r];
         s2_cqr_d[l]  = ctab[idx_qr];
      end
   end

   // Stage 3: quadrant fold and sign; optional conjugate
   always_comb begin
      fold_d = '0;
      re_v   = '0;
      im_v   = '0;
      for (int l = 0; l < LANES; l++) begin
         unique case (s2_quad_q[l])
            2'd0: begin re_v =  s2_cr_q[l];  im_v = -s2_cqr_q[l]; end
            2'd1: begin re_v = -s2_cqr_q[l]; im_v = -s2_cr_q[l];  end
            2'd2: begin re_v = -s2_cr_q[l];  im_v =  s2_cqr_q[l]; end
            default: begin re_v = s2_cqr_q[l]; im_v = s2_cr_q[l]; end
         endcase
         if (inv_eff) im_v = -im_v;
         fold_d[(LANES - 1 - l) * 2 * NBITS +: 2 * NBITS] = {re_v, im_v};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_k_q     <= '{default: '0};
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_quad_q  <= '{default: '0};
         s2_cr_q    <= '{default: '0};
         s2_cqr_q   <= '{default: '0};
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
      end else if (en) begin
         s1_valid_q <= issue;
         s1_last_q  <= issue && (cnt_q == CNTW'(1));
         s1_k_q     <= s1_k_d;
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
         s2_quad_q  <= s2_quad_d;
         s2_cr_q    <= s2_cr_d;
         s2_cqr_q   <= s2_cqr_d;
         out_valid  <= s2_valid_q;
         out_last   <= s2_valid_q && s2_last_q;
         if (s2_valid_q) out_data <= fold_d;
      end
   end

endmodule

// File: tb/tb_twiddle_stream_gen.sv
module tb_twiddle_stream_gen;

   localparam int NBITS = 11;
   localparam int LOG2N = 7;
   localparam int LANES = 4;
   localparam int CNTW  = 8;
   localparam int N     = 1 << LOG2N;
   localparam int W     = 2 * NBITS * LANES;
   localparam real Pi   = 3.14159265358979323846;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [LOG2N-1:0] k_base;
   logic [LOG2N-1:0] k_step;
   logic [CNTW-1:0]  beats;
`ifdef TWIDDLE_STREAM_INVERSE_EN
   logic             inverse;
`endif
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_last;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] got_d [$];
   bit           got_l [$];

   always #5 clk = ~clk;

   twiddle_stream_gen #(
      .NBITS (NBITS),
      .LOG2N (LOG2N),
      .LANES (LANES),
      .CNTW  (CNTW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_base    (k_base),
      .k_step    (k_step),
      .beats     (beats),
`ifdef TWIDDLE_STREAM_INVERSE_EN
      .inverse   (inverse),
`endif
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   // Record every accepted beat; inputs are steady at the falling edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_d.push_back(out_data);
         got_l.push_back(out_last);
      end
   end

   function automatic int rnd_away(real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(-v + 0.5);
   endfunction

   function automatic logic [W-1:0] put_lane(logic [W-1:0] d, int l, int re, int im);
      logic [NBITS-1:0] rb, ib;
      rb = re[NBITS-1:0];
      ib = im[NBITS-1:0];
      d[(LANES - 1 - l) * 2 * NBITS +: 2 * NBITS] = {rb, ib};
      return d;
   endfunction

   // Reference: direct evaluation of cos/-sin at the wrapped index.
   function automatic logic [W-1:0] model_beat(int kb, int st, int b, bit inv);
      logic [W-1:0] d;
      int k, re, im;
      real th;
      d = '0;
      for (int l = 0; l < LANES; l++) begin
         k  = (kb + (b * LANES + l) * st) % N;
         th = 2.0 * Pi * real'(k) / real'(N);
         re = rnd_away($cos(th) * real'(1 << (NBITS - 2)));
         im = -rnd_away($sin(th) * real'(1 << (NBITS - 2)));
         if (inv) im = -im;
         d = put_lane(d, l, re, im);
      end
      return d;
   endfunction

   task automatic step_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the sampling edge.
   task automatic do_start(input int kb, input int st, input int nb, input bit inv);
      k_base = kb[LOG2N-1:0];
      k_step = st[LOG2N-1:0];
      beats  = nb[CNTW-1:0];
`ifdef TWIDDLE_STREAM_INVERSE_EN
      inverse = inv;
`endif
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget, output bit timed_out);
      int cyc = 0;
      while (got_d.size() < n && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      timed_out = (got_d.size() < n);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_last); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
      step_cycles(2);
      rst_n = 1'b1;
      step_cycles(1);
   endtask

   task automatic test_forward_ramp;
      logic [W-1:0] exp_d;
      exp_d = '0;
      exp_d = put_lane(exp_d, 0, 512, 0);
      exp_d = put_lane(exp_d, 1, 511, -25);
      exp_d = put_lane(exp_d, 2, 510, -50);
      exp_d = put_lane(exp_d, 3, 506, -75);
      got_d.delete(); got_l.delete();
      out_ready = 1'b1;
      do_start(0, 1, 1, 1'b0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_e0 got %b want 1", busy); end
      for (int e = 1; e <= 2; e++) begin
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_early_valid e%0d got %b want 0", e, out_valid); end
         step_cycles(1);
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_early_valid e2 got %b want 0", out_valid); end
      step_cycles(1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_valid_e3 got %b want 1", out_valid); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL ramp_last got %b want 1", out_last); end
      n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL ramp_data got %h want %h", out_data, exp_d); end
      step_cycles(1);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_end got %b want 0", busy); end
      n_checks++; if (got_d.size() !== 1) begin n_fail++; $display("FAIL ramp_count got %0d want 1", got_d.size()); end
   endtask

   task automatic test_all_quadrants;
      logic [W-1:0] e0, e1;
      bit to;
      e0 = '0; e1 = '0;
      e0 = put_lane(e0, 0, 362, -362); e0 = put_lane(e0, 1, 0, -512);
      e0 = put_lane(e0, 2, -362, -362); e0 = put_lane(e0, 3, -512, 0);
      e1 = put_lane(e1, 0, -362, 362); e1 = put_lane(e1, 1, 0, 512);
      e1 = put_lane(e1, 2, 362, 362); e1 = put_lane(e1, 3, 512, 0);
      got_d.delete(); got_l.delete();
      do_start(16, 16, 2, 1'b0);
      wait_beats(2, 30, to);
      n_checks++;
      if (to) begin
         n_fail++; $display("FAIL quad_timeout got %0d beats want 2", got_d.size());
      end else begin
         n_checks += 3;
         if (got_d[0] !== e0) begin n_fail++; $display("FAIL quad_beat0 got %h want %h", got_d[0], e0); end
         if (got_d[1] !== e1) begin n_fail++; $display("FAIL quad_beat1 got %h want %h", got_d[1], e1); end
         if (got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin
            n_fail++; $display("FAIL quad_last got %b%b want 01", got_l[0], got_l[1]);
         end
      end
      step_cycles(2);
   endtask

   task automatic test_backpressure;
      int kb, st;
      bit to;
      kb = $urandom_range(0, N - 1);
      st = $urandom_range(0, N - 1);
      got_d.delete(); got_l.delete();
      out_ready = 1'b1;
      do_start(kb, st, 8, 1'b0);
      wait_beats(3, 30, to);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step_cycles(1);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== model_beat(kb, st, 3, 1'b0)) begin
            n_fail++;
            $display("FAIL bp_hold c%0d got v=%b %h want v=1 %h", c, out_valid, out_data,
                     model_beat(kb, st, 3, 1'b0));
         end
      end
      out_ready = 1'b1;
      wait_beats(8, 40, to);
      step_cycles(5);
      n_checks++;
      if (got_d.size() !== 8) begin
         n_fail++; $display("FAIL bp_count got %0d want 8", got_d.size());
      end else begin
         for (int b = 0; b < 8; b++) begin
            n_checks++;
            if (got_d[b] !== model_beat(kb, st, b, 1'b0) || got_l[b] !== (b == 7)) begin
               n_fail++;
               $display("FAIL bp_beat%0d got %h/%b want %h/%b", b, got_d[b], got_l[b],
                        model_beat(kb, st, b, 1'b0), b == 7);
            end
         end
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy got %b want 0", busy); end
   endtask

   task automatic test_ignored_requests;
      int kb, st;
      bit to;
      got_d.delete(); got_l.delete();
      out_ready = 1'b1;
      do_start(5, 3, 0, 1'b0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy); end
      step_cycles(6);
      n_checks++; if (got_d.size() !== 0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_output got %0d beats busy=%b want 0 0", got_d.size(), busy);
      end
      kb = $urandom_range(0, N - 1);
      st = $urandom_range(1, N - 1);
      do_start(kb, st, 6, 1'b0);
      step_cycles(2);
      do_start((kb + 7) % N, (st + 5) % N, 3, 1'b0);
      wait_beats(6, 40, to);
      step_cycles(6);
      n_checks++;
      if (got_d.size() !== 6) begin
         n_fail++; $display("FAIL busy_start_count got %0d want 6", got_d.size());
      end else begin
         for (int b = 0; b < 6; b++) begin
            n_checks++;
            if (got_d[b] !== model_beat(kb, st, b, 1'b0) || got_l[b] !== (b == 5)) begin
               n_fail++;
               $display("FAIL busy_start_beat%0d got %h/%b want %h/%b", b, got_d[b], got_l[b],
                        model_beat(kb, st, b, 1'b0), b == 5);
            end
         end
      end
   endtask

   task automatic test_reset_midstream;
      int kb, st;
      bit to;
      kb = $urandom_range(0, N - 1);
      st = $urandom_range(1, N - 1);
      got_d.delete(); got_l.delete();
      out_ready = 1'b1;
      do_start(kb, st, 8, 1'b0);
      wait_beats(4, 30, to);
      // Beat 4 is on the output now.
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs got busy=%b v=%b l=%b d=%h want all 0",
                  busy, out_valid, out_last, out_data);
      end
      step_cycles(2);
      rst_n = 1'b1;
      step_cycles(4);
      n_checks++;
      if (got_d.size() !== 4 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset_flush got %0d beats v=%b want 4 0", got_d.size(), out_valid);
      end
      for (int b = 0; b < got_d.size(); b++) begin
         n_checks++;
         if (got_d[b] !== model_beat(kb, st, b, 1'b0) || got_l[b] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pre_beat%0d got %h/%b", b, got_d[b], got_l[b]);
         end
      end
      got_d.delete(); got_l.delete();
      kb = $urandom_range(0, N - 1);
      st = $urandom_range(0, N - 1);
      do_start(kb, st, 5, 1'b0);
      wait_beats(5, 30, to);
      step_cycles(4);
      n_checks++;
      if (got_d.size() !== 5) begin
         n_fail++; $display("FAIL postreset_count got %0d want 5", got_d.size());
      end else begin
         for (int b = 0; b < 5; b++) begin
            n_checks++;
            if (got_d[b] !== model_beat(kb, st, b, 1'b0) || got_l[b] !== (b == 4)) begin
               n_fail++; $display("FAIL postreset_beat%0d got %h/%b want %h/%b", b, got_d[b],
                                  got_l[b], model_beat(kb, st, b, 1'b0), b == 4);
            end
         end
      end
   endtask

   task automatic test_random;
      int kb, st, nb, cyc;
      for (int it = 0; it < 8; it++) begin
         kb = $urandom_range(0, N - 1);
         st = $urandom_range(0, N - 1);
         nb = $urandom_range(1, 12);
         got_d.delete(); got_l.delete();
         out_ready = 1'b1;
         do_start(kb, st, nb, 1'b0);
         cyc = 0;
         while (got_d.size() < nb && cyc < 200) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step_cycles(1);
            cyc++;
         end
         out_ready = 1'b1;
         step_cycles(4);
         n_checks++;
         if (got_d.size() !== nb || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_count got %0d busy=%b want %0d 0", it, got_d.size(), busy, nb);
         end else begin
            for (int b = 0; b < nb; b++) begin
               n_checks++;
               if (got_d[b] !== model_beat(kb, st, b, 1'b0) || got_l[b] !== (b == nb - 1)) begin
                  n_fail++;
                  $display("FAIL rand%0d_beat%0d got %h/%b want %h/%b", it, b, got_d[b], got_l[b],
                           model_beat(kb, st, b, 1'b0), b == nb - 1);
               end
            end
         end
      end
   endtask

`ifdef TWIDDLE_STREAM_INVERSE_EN
   task automatic test_inverse;
      logic [W-1:0] exp_d;
      bit to;
      exp_d = '0;
      for (int l = 0; l < LANES; l++) exp_d = put_lane(exp_d, l, 0, 512);
      got_d.delete(); got_l.delete();
      out_ready = 1'b1;
      do_start(32, 0, 1, 1'b1);
      wait_beats(1, 20, to);
      n_checks++;
      if (to) begin
         n_fail++; $display("FAIL inverse_timeout got 0 beats want 1");
      end else if (got_d[0] !== exp_d) begin
         n_fail++; $display("FAIL inverse_data got %h want %h", got_d[0], exp_d);
      end
      step_cycles(3);
      inverse = 1'b0;
   endtask
`endif

   initial begin
      start     = 1'b0;
      k_base    = '0;
      k_step    = '0;
      beats     = '0;
      out_ready = 1'b1;
`ifdef TWIDDLE_STREAM_INVERSE_EN
      inverse   = 1'b0;
`endif
      test_reset();
      test_forward_ramp();
      test_all_quadrants();
      test_backpressure();
      test_ignored_requests();
      test_reset_midstream();
      test_random();
`ifdef TWIDDLE_STREAM_INVERSE_EN
      test_inverse();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/twiddle_stream_gen.md
# twiddle_stream_gen

Streaming twiddle-factor generator for the parallel FFT datapath. It replaces fixed per-stage coefficient constants with a runtime-programmable sequence. On a start request it emits `beats` output beats. Each beat carries LANES complex twiddles W_N^k = cos(2πk/N) − j·sin(2πk/N), with k = k_base + i·k_step mod N. The block sits between the FFT stage controller and the butterfly multipliers, and uses a valid/ready output handshake so the stage pipeline can apply backpressure.

## Interface
- NBITS, 11, width of each real/imag component, signed two's complement; 1.0 = 2^(NBITS-2)
- LOG2N, 7, log2 of FFT size N (N = 128 by default); LOG2N ≥ 3
- LANES, 4, complex twiddles per beat
- CNTW, 8, width of the beat-count field
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only when busy = 0
- k_base  in  LOG2N  first twiddle index, sampled with start
- k_step  in  LOG2N  index increment per twiddle, sampled with start
- beats  in  CNTW  number of output beats, sampled with start
- busy  out  1  request in progress
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready
- out_data  out  2·NBITS·LANES  packed twiddles; lane 0 in MSBs; each lane {re, im}, with re in the upper NBITS
- out_last  out  1  marks the final beat of a request

## Operation
- Quarter-wave table C[m] = round(cos(2πm/N)·2^(NBITS-2)) for m = 0..N/4, computed at elaboration. Rounding is to nearest, with ties away from zero.
- Index mapping: k is split into q = k[LOG2N-1:LOG2N-2] and r = k[LOG2N-3:0], with Q = N/4.
  - q=0 gives {C[r], −C[Q−r]}
  - q=1 gives {−C[Q−r], −C[r]}
  - q=2 gives {−C[r], C[Q−r]}
  - q=3 gives {C[Q−r], C[r]}
- Lane l of beat b uses index k = k_base + (b·LANES + l)·k_step. The addition wraps mod N, with no saturation.
- FSM:
  - IDLE: start & beats≠0 latches the request and goes to RUN. start with beats = 0 is ignored and stays in IDLE.
  - RUN: issues one beat per enabled cycle. After issuing beat beats−1, go to DRAIN.
  - DRAIN: wait until the last beat is accepted, then go to IDLE.
- start while busy = 1 is ignored. The latched request is unaffected.
- Pipeline enable = !out_valid | out_ready. All stages stall together, and out_data is held stable while stalled.

## Timing
- Reset (asynchronous, immediate) sets: busy = 0, out_valid = 0, out_last = 0, out_data = 0, FSM = IDLE, pipeline emptied.
- 3-stage pipeline: index compute, table read, quadrant fold/negate register.
- Start to first data: start sampled at edge E0 gives busy = 1 after E0 and out_valid = 1 after E3, provided out_ready was high throughout.
- Throughput: one beat per cycle while out_ready = 1.
- out_last = 1 only on beat beats−1. busy falls on the edge that accepts that beat.
- A reset asserted mid-request discards all in-flight beats. No out_last is emitted for the aborted request.

## Configuration
- TWIDDLE_STREAM_INVERSE_EN defined:
  - Adds input port `inverse` (1 bit), sampled with start.
  - When inverse = 1, every lane outputs the conjugate, i.e. the imag component is negated (W_N^−k) for IFFT use.
- Not defined: the port is absent, and the block always emits forward twiddles.

## Test plan
- Forward ramp: NBITS=11, LOG2N=7, LANES=4; start with k_base=0, k_step=1, beats=1 → one beat with lanes {512,0}, {511,−25}, {510,−50}, {506,−75}; out_last=1; first out_valid 3 edges after start.
- All quadrants: k_base=16, k_step=16, beats=2.
  - Beat 0: {362,−362}, {0,−512}, {−362,−362}, {−512,0}
  - Beat 1: {−362,362}, {0,512}, {362,362}, {512,0}, with out_last on beat 1 only
- Backpressure: beats=8, out_ready low for 5 cycles after beat 2 → out_data held constant while stalled; all 8 beats delivered in order with no duplicates.
- Ignored requests: start with beats=0 → busy stays 0 and no output. A second start while busy → the original sequence completes unchanged.
- Reset mid-stream: rst_n low during beat 4 of 8 → all outputs 0 immediately. After release, a new start produces a correct sequence.
- With TWIDDLE_STREAM_INVERSE_EN: inverse=1, k_base=32, k_step=0, beats=1 → all lanes {0,512}.
